dcache_controller: RTL and testbench



---
 rtl/dcache_controller_pkg.sv | 26 ++
 rtl/dcache_array.sv | 58 +++++
 rtl/dcache_controller.sv | 156 +++++++++++++++
 tb/tb_dcache_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_controller_pkg.sv
// Shared types and geometry for the direct-mapped data cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dcache_controller_pkg;

  localparam int TAG_W      = 3;
  localparam int INDEX_W    = 3;
  localparam int OFFSET_W   = 2;
  localparam int BLOCK_W    = 32;
  localparam int NUM_SETS   = 8;
  localparam int MEM_ADDR_W = TAG_W + INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  // Byte 0 of a block lives in bits [7:0].
  function automatic logic [7:0] block_byte(input logic [BLOCK_W-1:0] blk,
                                            input logic [OFFSET_W-1:0] off);
    return blk[{off, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Storage for the cache: per-set valid, dirty, tag and 32-bit block.
// Latency: combinational read; byte write / block allocate commit at the next CLK edge.
// Backpressure: none; the controller sequences all updates.
// Ports: CLK, RESET (sync, active-low, clears valid/dirty only),
//   i_index/i_offset select the set and byte, i_byte_we + i_wdata write one byte and
//   mark the set dirty, i_alloc + i_alloc_tag + i_alloc_block refill a set clean,
//   o_valid/o_dirty/o_tag/o_block read the indexed set.
module dcache_array
  import dcache_controller_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic [INDEX_W-1:0]  i_index,
  input  logic [OFFSET_W-1:0] i_offset,
  input  logic                i_byte_we,
  input  logic [7:0]          i_wdata,
  input  logic                i_alloc,
  input  logic [TAG_W-1:0]    i_alloc_tag,
  input  logic [BLOCK_W-1:0]  i_alloc_block,
  output logic                o_valid,
  output logic                o_dirty,
  output logic [TAG_W-1:0]    o_tag,
  output logic [BLOCK_W-1:0]  o_block
);

  logic [NUM_SETS-1:0] r_valid;
  logic [NUM_SETS-1:0] r_dirty;
  logic [TAG_W-1:0]    r_tag   [NUM_SETS];
  logic [BLOCK_W-1:0]  r_block [NUM_SETS];

  // Status bits are the only state reset touches; dirty data is simply dropped.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_alloc) begin
      r_valid[i_index] <= 1'b1;
      r_dirty[i_index] <= 1'b0;
    end else if (i_byte_we) begin
      r_dirty[i_index] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (i_alloc) begin
      r_tag[i_index]   <= i_alloc_tag;
      r_block[i_index] <= i_alloc_block;
    end else if (i_byte_we) begin
      r_block[i_index][{i_offset, 3'b000} +: 8] <= i_wdata;
    end
  end

  assign o_valid = r_valid[i_index];
  assign o_dirty = r_dirty[i_index];
  assign o_tag   = r_tag[i_index];
  assign o_block = r_block[i_index];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back write-allocate data cache, 8 sets x 4-byte blocks.
// Latency: read hit 0 cycles, write hit commits next edge; miss stalls 1+Tf+1 (+Tw if dirty).
// Backpressure: BUSYWAIT stalls the CPU; mem_busywait holds WRITEBACK/FETCH.
// Ports: CLK, RESET (sync, active-low); CPU side READ/WRITE/ADDRESS/WRITEDATA ->
//   READDATA/BUSYWAIT; memory side mem_read/mem_write/mem_address/mem_writedata,
//   mem_readdata/mem_busywait; HIT_COUNT/MISS_COUNT statistics.
// Optional: define DCACHE_STATS_EN to build the saturating hit/miss counters;
//   otherwise both counters read 16'h0000.
module dcache_controller
  import dcache_controller_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [7:0]            ADDRESS,
  input  logic [7:0]            WRITEDATA,
  output logic [7:0]            READDATA,
  output logic                  BUSYWAIT,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_address,
  output logic [BLOCK_W-1:0]    mem_writedata,
  input  logic [BLOCK_W-1:0]    mem_readdata,
  input  logic                  mem_busywait,
  output logic [15:0]           HIT_COUNT,
  output logic [15:0]           MISS_COUNT
);

  state_t r_state;
  state_t w_next_state;

  logic [TAG_W-1:0]    w_addr_tag;
  logic [INDEX_W-1:0]  w_index;
  logic [OFFSET_W-1:0] w_offset;
  logic                w_valid;
  logic                w_dirty;
  logic [TAG_W-1:0]    w_tag;
  logic [BLOCK_W-1:0]  w_block;
  logic                w_req;
  logic                w_hit;
  logic                w_byte_we;
  logic                w_alloc;
  logic [7:0]          w_sel_byte;
  logic [7:0]          r_readdata;

  assign w_addr_tag = ADDRESS[7:5];
  assign w_index    = ADDRESS[4:2];
  assign w_offset   = ADDRESS[1:0];

  assign w_req      = READ | WRITE;
  assign w_hit      = w_valid && (w_tag == w_addr_tag);
  assign w_byte_we  = (r_state == IDLE) && w_hit && WRITE;
  assign w_alloc    = (r_state == ALLOCATE);
  assign w_sel_byte = block_byte(w_block, w_offset);

  dcache_array u_array (
    .CLK           (CLK),
    .RESET         (RESET),
    .i_index       (w_index),
    .i_offset      (w_offset),
    .i_byte_we     (w_byte_we),
    .i_wdata       (WRITEDATA),
    .i_alloc       (w_alloc),
    .i_alloc_tag   (w_addr_tag),
    .i_alloc_block (mem_readdata),
    .o_valid       (w_valid),
    .o_dirty       (w_dirty),
    .o_tag         (w_tag),
    .o_block       (w_block)
  );

  // Stall is purely combinational so a hit in IDLE never costs a cycle.
  assign BUSYWAIT = w_req && !((r_state == IDLE) && w_hit);

  // Load data is live during a read hit and otherwise holds the last hit byte.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_readdata <= 8'h00;
    end else if (READ && w_hit) begin
      r_readdata <= w_sel_byte;
    end
  end

  assign READDATA = (READ && w_hit) ? w_sel_byte : r_readdata;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = {w_addr_tag, w_index};
    mem_writedata = w_block;
    case (r_state)
      IDLE: begin
        if (w_req && !w_hit) begin
          w_next_state = (w_valid && w_dirty) ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        mem_write   = 1'b1;
        // Victim goes back to the address it was fetched from.
        mem_address = {w_tag, w_index};
        if (!mem_busywait) begin
          w_next_state = FETCH;
        end
      end
      FETCH: begin
        mem_read = 1'b1;
        if (!mem_busywait) begin
          w_next_state = ALLOCATE;
        end
      end
      ALLOCATE: begin
        // Access replays as a hit in IDLE, which also merges write-miss data.
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_hit_count  <= 16'h0000;
      r_miss_count <= 16'h0000;
    end else if (r_state == IDLE && w_req) begin
      if (w_hit && r_hit_count != 16'hFFFF) begin
        r_hit_count <= r_hit_count + 16'd1;
      end
      if (!w_hit && r_miss_count != 16'hFFFF) begin
        r_miss_count <= r_miss_count + 16'd1;
      end
    end
  end

  assign HIT_COUNT  = r_hit_count;
  assign MISS_COUNT = r_miss_count;
`else
  assign HIT_COUNT  = 16'h0000;
  assign MISS_COUNT = 16'h0000;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a 4-cycle-busy block memory model.
// Latency: n/a.
// Backpressure: memory model holds mem_busywait high for 4 cycles per request.
module tb_dcache_controller;
  import dcache_controller_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        READ = 1'b0;
  logic        WRITE = 1'b0;
  logic [7:0]  ADDRESS = 8'h00;
  logic [7:0]  WRITEDATA = 8'h00;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;
  logic [15:0] HIT_COUNT;
  logic [15:0] MISS_COUNT;

  dcache_controller dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait),
    .HIT_COUNT     (HIT_COUNT),
    .MISS_COUNT    (MISS_COUNT)
  );

  always #5 CLK = ~CLK;

  // Block at address a holds bytes {D0+a, C0+a, B0+a, A0+a}.
  function automatic logic [31:0] blk(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {8'hD0 + b, 8'hC0 + b, 8'hB0 + b, 8'hA0 + b};
  endfunction

  logic [31:0] mem [64];
  logic [2:0]  mem_cnt = 3'd0;
  logic [5:0]  lat_addr = 6'd0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = blk(i);
  end

  assign mem_busywait = (mem_read || mem_write) && (mem_cnt != 3'd4);
  assign mem_readdata = mem[lat_addr];

  always @(posedge CLK) begin
    if (mem_read || mem_write) mem_cnt <= (mem_cnt == 3'd4) ? 3'd0 : mem_cnt + 3'd1;
    else                       mem_cnt <= 3'd0;
    if (mem_read) lat_addr <= mem_address;
    if (mem_write && !mem_busywait) mem[mem_address] <= mem_writedata;
  end

  // Bus observations, cleared at the start of each access.
  logic        saw_rd = 1'b0, saw_wr = 1'b0, both_hi = 1'b0;
  logic [5:0]  rd_addr = 6'd0, wr_addr = 6'd0;
  logic [31:0] wr_data = 32'd0;

  always @(negedge CLK) begin
    if (mem_read)  begin saw_rd <= 1'b1; rd_addr <= mem_address; end
    if (mem_write) begin saw_wr <= 1'b1; wr_addr <= mem_address; wr_data <= mem_writedata; end
    if (mem_read && mem_write) both_hi <= 1'b1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int exp_hit  = 0;
  int exp_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Holds the request until BUSYWAIT drops, samples READDATA, then lets one edge commit it.
  task automatic do_access(input logic rd, input logic wr, input logic [7:0] addr,
                           input logic [7:0] data, output int busy, output logic [7:0] rdata);
    saw_rd = 1'b0;
    saw_wr = 1'b0;
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = data;
    busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (!BUSYWAIT) break;
      busy++;
    end
    if (BUSYWAIT) begin
      n_checks++;
      n_fail++;
      $display("FAIL access_timeout: addr %0h still stalled", addr);
    end
    rdata = READDATA;
    @(posedge CLK);
    #1;
    READ = 1'b0;
    WRITE = 1'b0;
  endtask

  task automatic check_stats(input string tag);
`ifdef DCACHE_STATS_EN
    check_eq({tag, "_hits"}, 32'(HIT_COUNT), 32'(exp_hit));
    check_eq({tag, "_misses"}, 32'(MISS_COUNT), 32'(exp_miss));
`else
    check_eq({tag, "_hits"}, 32'(HIT_COUNT), 32'h0);
    check_eq({tag, "_misses"}, 32'(MISS_COUNT), 32'h0);
`endif
  endtask

  int         busy;
  logic [7:0] rdata;
  logic       got_fetch;

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_busywait", 32'(BUSYWAIT), 32'h0);
    check_eq("rst_mem_read", 32'(mem_read), 32'h0);
    check_eq("rst_mem_write", 32'(mem_write), 32'h0);
    check_eq("rst_readdata", 32'(READDATA), 32'h00);
    check_eq("rst_hit_cnt", 32'(HIT_COUNT), 32'h0);
    check_eq("rst_miss_cnt", 32'(MISS_COUNT), 32'h0);
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    // Cold read miss, clean: 1 + 5 + 1 stall cycles.
    do_access(1'b1, 1'b0, 8'h00, 8'h00, busy, rdata);
    exp_hit++; exp_miss++;
    check_eq("cold_busy", 32'(busy), 32'd7);
    check_eq("cold_fetch_seen", 32'(saw_rd), 32'h1);
    check_eq("cold_fetch_addr", 32'(rd_addr), 32'h00);
    check_eq("cold_no_wb", 32'(saw_wr), 32'h0);
    check_eq("cold_rdata", 32'(rdata), 32'hA0);

    // Write hit then read hit: no stall.
    do_access(1'b0, 1'b1, 8'h00, 8'hA5, busy, rdata);
    exp_hit++;
    check_eq("wr_hit_busy", 32'(busy), 32'd0);
    do_access(1'b1, 1'b0, 8'h00, 8'h00, busy, rdata);
    exp_hit++;
    check_eq("rd_hit_busy", 32'(busy), 32'd0);
    check_eq("rd_hit_rdata", 32'(rdata), 32'hA5);

    // Conflict on index 0 with dirty victim: writeback then fetch, 12 stall cycles.
    do_access(1'b1, 1'b0, 8'h20, 8'h00, busy, rdata);
    exp_hit++; exp_miss++;
    check_eq("dirty_busy", 32'(busy), 32'd12);
    check_eq("dirty_wb_addr", 32'(wr_addr), 32'h00);
    check_eq("dirty_wb_byte0", 32'(wr_data[7:0]), 32'hA5);
    check_eq("dirty_wb_block", wr_data, 32'hD0C0B0A5);
    check_eq("dirty_fetch_addr", 32'(rd_addr), 32'h08);
    check_eq("dirty_rdata", 32'(rdata), 32'hA8);

    // Write miss on clean, invalid set 1: fetch block 0x11 then merge byte 3.
    do_access(1'b0, 1'b1, 8'h47, 8'h3C, busy, rdata);
    exp_hit++; exp_miss++;
    check_eq("wmiss_busy", 32'(busy), 32'd7);
    check_eq("wmiss_fetch_addr", 32'(rd_addr), 32'h11);
    check_eq("wmiss_no_wb", 32'(saw_wr), 32'h0);
    do_access(1'b1, 1'b0, 8'h47, 8'h00, busy, rdata);
    exp_hit++;
    check_eq("wmiss_merged", 32'(rdata), 32'h3C);
    check_eq("wmiss_rd_busy", 32'(busy), 32'd0);
    do_access(1'b1, 1'b0, 8'h44, 8'h00, busy, rdata);
    exp_hit++;
    check_eq("wmiss_byte0", 32'(rdata), 32'hB1);
    do_access(1'b1, 1'b0, 8'h46, 8'h00, busy, rdata);
    exp_hit++;
    check_eq("wmiss_byte2", 32'(rdata), 32'hD1);
    check_stats("seq");

    // Reset asserted in the middle of a fetch.
    READ = 1'b1; ADDRESS = 8'h6C;
    got_fetch = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (mem_read) begin got_fetch = 1'b1; break; end
    end
    check_eq("midrst_fetch_started", 32'(got_fetch), 32'h1);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    check_eq("midrst_mem_read", 32'(mem_read), 32'h0);
    check_eq("midrst_mem_write", 32'(mem_write), 32'h0);
    check_eq("midrst_state", 32'(dut.r_state), 32'(IDLE));
    READ = 1'b0;
    RESET = 1'b1;
    #1;
    check_eq("midrst_busywait", 32'(BUSYWAIT), 32'h0);
    check_eq("midrst_readdata", 32'(READDATA), 32'h00);
    check_eq("midrst_hit_cnt", 32'(HIT_COUNT), 32'h0);
    check_eq("midrst_miss_cnt", 32'(MISS_COUNT), 32'h0);
    exp_hit = 0; exp_miss = 0;

    // Same address misses again: valid bits were cleared.
    do_access(1'b1, 1'b0, 8'h6C, 8'h00, busy, rdata);
    exp_hit++; exp_miss++;
    check_eq("post_rst_busy", 32'(busy), 32'd7);
    check_eq("post_rst_fetch_addr", 32'(rd_addr), 32'h1B);
    check_eq("post_rst_rdata", 32'(rdata), 32'hBB);
    // Previously valid set 0 was invalidated as well.
    do_access(1'b1, 1'b0, 8'h20, 8'h00, busy, rdata);
    exp_hit++; exp_miss++;
    check_eq("post_rst_set0_busy", 32'(busy), 32'd7);
    check_eq("post_rst_set0_no_wb", 32'(saw_wr), 32'h0);
    check_stats("final");

    check_eq("rd_wr_exclusive", 32'(both_hi), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
